// File: rtl/tri_stream_loader.sv
// Byte-stream packet decoder: assembles fixed-size triangle records into RAM
// words and publishes the triangle count only once the packet checksum verifies.
module tri_stream_loader #(
   parameter int unsigned N_TRIS    = 430,
   parameter int unsigned TRI_BYTES = 40,
   parameter int unsigned ADDR_W    = 9,
   parameter logic [7:0]  HEADER    = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   hold,
   output logic                   mem_we,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic [8*TRI_BYTES-1:0] mem_wdata,
   output logic [15:0]            tri_count,
   output logic                   commit,
   output logic                   err_checksum,
   output logic                   err_overflow,
   output logic                   busy
);

   localparam int unsigned REC_W  = 8 * TRI_BYTES;
   localparam int unsigned BIDX_W = (TRI_BYTES > 1) ? $clog2(TRI_BYTES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_LO,
      S_CNT_HI,
      S_PAYLOAD,
      S_CHECK
   } state_t;

   state_t              state;
   logic [7:0]          cnt_lo;
   logic [7:0]          xor_acc;
   logic [15:0]         count;
   logic [BIDX_W-1:0]   byte_idx;
   logic [ADDR_W-1:0]   rec_idx;
   logic [REC_W-1:0]    record;
   logic [REC_W-1:0]    rec_next;
   logic [15:0]         cnt_in;
   logic                accept;
   logic                rec_last;
   logic                pkt_last;

   // hold is the only combinational path to an output
   assign in_ready = !hold;
   assign accept   = in_valid && !hold;
   assign cnt_in   = {in_data, cnt_lo};
   assign rec_last = (byte_idx == BIDX_W'(TRI_BYTES - 1));
   assign pkt_last = (16'(rec_idx) == (count - 16'd1));

   // Record with the incoming byte placed at its byte position
   always_comb begin
      rec_next = record;
      for (int i = 0; i < int'(TRI_BYTES); i++) begin
         if (byte_idx == BIDX_W'(i)) begin
            rec_next[i*8 +: 8] = in_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt_lo       <= '0;
         count        <= '0;
         xor_acc      <= '0;
         byte_idx     <= '0;
         rec_idx      <= '0;
         record       <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         tri_count    <= '0;
         commit       <= 1'b0;
         err_checksum <= 1'b0;
         err_overflow <= 1'b0;
         busy         <= 1'b0;
      end else begin
         mem_we       <= 1'b0;
         commit       <= 1'b0;
         err_checksum <= 1'b0;
         err_overflow <= 1'b0;
         if (accept) begin
            case (state)
               S_IDLE: begin
                  if (in_data == HEADER) begin
                     state    <= S_CNT_LO;
                     busy     <= 1'b1;
                     xor_acc  <= '0;
                     byte_idx <= '0;
                     rec_idx  <= '0;
                  end
               end
               S_CNT_LO: begin
                  cnt_lo  <= in_data;
                  xor_acc <= xor_acc ^ in_data;
                  state   <= S_CNT_HI;
               end
               S_CNT_HI: begin
                  count   <= cnt_in;
                  xor_acc <= xor_acc ^ in_data;
                  if (cnt_in > 16'(N_TRIS)) begin
                     err_overflow <= 1'b1;
                     state        <= S_IDLE;
                     busy         <= 1'b0;
                  end else if (cnt_in == 16'd0) begin
                     state <= S_CHECK;
                  end else begin
                     state <= S_PAYLOAD;
                  end
               end
               S_PAYLOAD: begin
                  record  <= rec_next;
                  xor_acc <= xor_acc ^ in_data;
                  if (rec_last) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= rec_idx;
                     mem_wdata <= rec_next;
                     byte_idx  <= '0;
                     rec_idx   <= rec_idx + ADDR_W'(1);
                     if (pkt_last) begin
                        state <= S_CHECK;
                     end
                  end else begin
                     byte_idx <= byte_idx + BIDX_W'(1);
                  end
               end
               S_CHECK: begin
                  // Failed packets leave the previous count bounding the feeder
                  if (in_data == xor_acc) begin
                     tri_count <= count;
                     commit    <= 1'b1;
                  end else begin
                     err_checksum <= 1'b1;
                  end
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tri_stream_loader.sv
// Randomized bench for tri_stream_loader against a packet-level reference model.
module tb_tri_stream_loader;

   localparam int unsigned N_TRIS    = 430;
   localparam int unsigned TRI_BYTES = 40;
   localparam int unsigned ADDR_W    = 9;
   localparam int unsigned RW        = 8 * TRI_BYTES;

   logic              clk = 1'b0;
   logic              rst;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              hold;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [RW-1:0]     mem_wdata;
   logic [15:0]       tri_count;
   logic              commit;
   logic              err_checksum;
   logic              err_overflow;
   logic              busy;

   always #5 clk = ~clk;

   tri_stream_loader #(
      .N_TRIS(N_TRIS), .TRI_BYTES(TRI_BYTES), .ADDR_W(ADDR_W), .HEADER(8'hA5)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .hold(hold), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .tri_count(tri_count), .commit(commit),
      .err_checksum(err_checksum), .err_overflow(err_overflow), .busy(busy)
   );

   typedef struct {
      int            addr;
      logic [RW-1:0] data;
      int            cyc;
   } wr_t;

   int  tests = 0;
   int  fails = 0;
   int  cyc   = 0;
   int  n_commit = 0, n_echk = 0, n_eov = 0;
   int  commit_cyc = -1, echk_cyc = -1, eov_cyc = -1;
   int  exp_count = 0;
   wr_t got_q[$];
   wr_t exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // Observed writes and pulses, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_we) got_q.push_back('{int'(mem_addr), mem_wdata, cyc});
         if (commit) begin n_commit++; commit_cyc = cyc; end
         if (err_checksum) begin n_echk++; echk_cyc = cyc; end
         if (err_overflow) begin n_eov++; eov_cyc = cyc; end
      end
   end

   task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Offer one byte until accepted; mode 1 toggles hold every 3 cycles and randomizes valid
   task automatic send_byte(input logic [7:0] b, input int mode, output int acc);
      int  tries = 0;
      bit  done  = 0;
      bit  took;
      acc = -1;
      while (!done) begin
         hold     = (mode != 0) ? (((cyc / 3) % 2) == 1) : 1'b0;
         in_valid = (mode != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
         in_data  = b;
         #1;
         if (tries < 3) check("in_ready", RW'(in_ready), RW'(!hold));
         @(posedge clk);
         took = in_valid && !hold;
         @(negedge clk);
         tries++;
         if (took) begin
            done = 1;
            acc  = cyc;
         end else if (tries > 200) begin
            check("byte_timeout", RW'(1), RW'(0));
            done = 1;
         end
      end
   endtask

   task automatic finish_packet();
      in_valid = 1'b0;
      hold     = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic compare_writes();
      check("wr_count", RW'(got_q.size()), RW'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         check("wr_addr", RW'(got_q[i].addr), RW'(exp_q[i].addr));
         check("wr_data", got_q[i].data, exp_q[i].data);
         check("wr_cycle", RW'(got_q[i].cyc), RW'(exp_q[i].cyc));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic send_packet(input int cnt, input int mode, input bit bad, input bit incr);
      logic [7:0]    lo, hi, v, x;
      logic [RW-1:0] rec;
      int            acc;
      int            c0, e0, o0;
      c0 = n_commit; e0 = n_echk; o0 = n_eov;
      lo = 8'(cnt);
      hi = 8'(cnt >> 8);
      x  = lo ^ hi;
      send_byte(8'hA5, mode, acc);
      send_byte(lo, mode, acc);
      send_byte(hi, mode, acc);
      if (cnt > int'(N_TRIS)) begin
         finish_packet();
         check("ovf_pulse", RW'(n_eov - o0), RW'(1));
         check("ovf_cycle", RW'(eov_cyc), RW'(acc));
         check("ovf_commit", RW'(n_commit - c0), RW'(0));
      end else begin
         for (int r = 0; r < cnt; r++) begin
            rec = '0;
            for (int b = 0; b < int'(TRI_BYTES); b++) begin
               v = incr ? 8'(r * int'(TRI_BYTES) + b) : 8'($urandom);
               rec[b*8 +: 8] = v;
               x = x ^ v;
               send_byte(v, mode, acc);
            end
            exp_q.push_back('{r, rec, acc});
         end
         send_byte(bad ? (x ^ 8'h01) : x, mode, acc);
         finish_packet();
         if (bad) begin
            check("chk_err_pulse", RW'(n_echk - e0), RW'(1));
            check("chk_err_cycle", RW'(echk_cyc), RW'(acc));
            check("chk_no_commit", RW'(n_commit - c0), RW'(0));
         end else begin
            check("commit_pulse", RW'(n_commit - c0), RW'(1));
            check("commit_cycle", RW'(commit_cyc), RW'(acc));
            check("no_chk_err", RW'(n_echk - e0), RW'(0));
            exp_count = cnt;
         end
      end
      check("tri_count", RW'(tri_count), RW'(exp_count));
      check("busy_idle", RW'(busy), RW'(0));
      compare_writes();
   endtask

   initial begin
      int acc;
      logic [7:0] v;
      rst = 1'b1; hold = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
      // Reset while bytes keep streaming
      repeat (2) begin
         @(negedge clk);
         in_data = 8'($urandom);
      end
      check("rst_tri_count", RW'(tri_count), RW'(0));
      check("rst_pulses", RW'({mem_we, commit, err_checksum, err_overflow}), RW'(0));
      check("rst_busy", RW'(busy), RW'(0));
      check("rst_addr_data", RW'(mem_addr) | mem_wdata, RW'(0));
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);

      send_packet(1, 0, 1'b0, 1'b1);
      send_packet(3, 0, 1'b0, 1'b1);
      send_packet(3, 0, 1'b1, 1'b1);
      send_packet(431, 0, 1'b0, 1'b0);
      send_packet(0, 0, 1'b0, 1'b0);
      send_packet(2, 1, 1'b0, 1'b0);

      // Garbage, then reset partway through record 0
      for (int i = 0; i < 5; i++) begin
         v = 8'($urandom);
         if (v == 8'hA5) v = 8'h00;
         send_byte(v, 0, acc);
      end
      send_byte(8'hA5, 0, acc);
      send_byte(8'h01, 0, acc);
      send_byte(8'h00, 0, acc);
      for (int i = 0; i < 17; i++) send_byte(8'($urandom), 0, acc);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_count = 0;
      check("midrst_busy", RW'(busy), RW'(0));
      check("midrst_count", RW'(tri_count), RW'(0));
      check("midrst_no_wr", RW'(got_q.size()), RW'(0));
      got_q.delete();
      send_packet(1, 0, 1'b0, 1'b0);

      for (int k = 0; k < 6; k++) begin
         send_packet($urandom_range(0, 4), $urandom_range(0, 1),
                     ($urandom_range(0, 3) == 0), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
